// File: rtl/loader_pkg.sv
// Shared types and constants for the UART-to-RAM loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CSUM,
        DONE,
        ERR
    } loader_state_e;

    localparam int unsigned CSUM_W = 8;

    // Bytes per RAM word; DATA_W must be a multiple of 8.
    function automatic int unsigned bpw(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/uart_ram_loader_if.sv
// RAM write port driven by the loader (master) and consumed by the RAM (slave).
interface uart_ram_loader_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 15
);
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;

    modport master (output wr_data, output wr_addr, output wr_en);
    modport slave  (input  wr_data, input  wr_addr, input  wr_en);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle uart_rx_done per byte, data held until next byte.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic       uart_rx_done,
    output logic [7:0] uart_rx_data
);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    localparam logic [15:0] HalfBit = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FullBit = 16'(CLKS_PER_BIT - 1);

    rx_state_e   state_q;
    logic        rxd_s1_q, rxd_s2_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= RxIdle;
            rxd_s1_q     <= 1'b1;
            rxd_s2_q     <= 1'b1;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            uart_rx_done <= 1'b0;
            uart_rx_data <= '0;
        end else begin
            rxd_s1_q     <= uart_rxd;
            rxd_s2_q     <= rxd_s1_q;
            uart_rx_done <= 1'b0;
            unique case (state_q)
                RxIdle: begin
                    cnt_q <= '0;
                    if (!rxd_s2_q) state_q <= RxStart;
                end
                RxStart: begin
                    if (cnt_q == HalfBit) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        // A start bit that is gone by mid-bit is treated as a glitch.
                        state_q   <= rxd_s2_q ? RxIdle : RxData;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RxData: begin
                    if (cnt_q == FullBit) begin
                        cnt_q   <= '0;
                        shift_q <= {rxd_s2_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) state_q <= RxStop;
                        else bit_idx_q <= bit_idx_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RxStop: begin
                    if (cnt_q == FullBit) begin
                        cnt_q   <= '0;
                        state_q <= RxIdle;
                        if (rxd_s2_q) begin
                            uart_rx_data <= shift_q;
                            uart_rx_done <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= RxIdle;
            endcase
        end
    end

endmodule

// File: rtl/uart_ram_loader.sv
// Packs UART bytes little-endian into DATA_W words and writes them to RAM from load_base.
// Define UART_LOADER_CSUM_EN to require and verify a mod-256 checksum trailer byte.
module uart_ram_loader
    import loader_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ADDR_W       = 15,
    parameter int unsigned TIMEOUT_CYC  = 1_000_000,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              uart_rxd,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W-1:0] load_len,
    uart_ram_loader_if.master ram_wr,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [CSUM_W-1:0] load_csum
);

    localparam int unsigned BPW = bpw(DATA_W);
    localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;

    logic              uart_rx_done;
    logic [7:0]        uart_rx_data;
    logic              d0, d1, rx_pulse;
    loader_state_e     state_q;
    logic [ADDR_W-1:0] base_q, len_q, word_cnt_q;
    logic [BCW-1:0]    byte_cnt_q;
    logic [DATA_W-1:0] shift_q, word_next;
    logic [31:0]       timer_q;
    logic              last_lane, last_word, timeout_hit;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .uart_rxd    (uart_rxd),
        .uart_rx_done(uart_rx_done),
        .uart_rx_data(uart_rx_data)
    );

    assign rx_pulse    = d0 & ~d1;
    assign last_lane   = (byte_cnt_q == BCW'(BPW - 1));
    assign last_word   = (word_cnt_q == len_q - ADDR_W'(1));
    assign timeout_hit = (TIMEOUT_CYC != 0) && (timer_q == TIMEOUT_CYC);

    always_comb begin
        word_next = shift_q;
        word_next[8*byte_cnt_q +: 8] = uart_rx_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= IDLE;
            d0             <= 1'b0;
            d1             <= 1'b0;
            base_q         <= '0;
            len_q          <= '0;
            word_cnt_q     <= '0;
            byte_cnt_q     <= '0;
            shift_q        <= '0;
            timer_q        <= '0;
            ram_wr.wr_en   <= 1'b0;
            ram_wr.wr_addr <= '0;
            ram_wr.wr_data <= '0;
            load_busy      <= 1'b0;
            load_done      <= 1'b0;
            load_err       <= 1'b0;
            load_csum      <= '0;
        end else begin
            d0           <= uart_rx_done;
            d1           <= d0;
            ram_wr.wr_en <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!load_start) begin
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                    end else if (!load_done && !load_err) begin
                        base_q     <= load_base;
                        len_q      <= load_len;
                        word_cnt_q <= '0;
                        byte_cnt_q <= '0;
                        load_csum  <= '0;
                        timer_q    <= '0;
                        load_busy  <= 1'b1;
                        state_q    <= (load_len == '0) ? DONE : RECV;
                    end
                end
                RECV: begin
                    if (!load_start) begin
                        load_busy <= 1'b0;
                        state_q   <= IDLE;
                    end else if (rx_pulse) begin
                        timer_q   <= '0;
                        load_csum <= load_csum + uart_rx_data;
                        shift_q   <= word_next;
                        if (last_lane) begin
                            byte_cnt_q     <= '0;
                            ram_wr.wr_en   <= 1'b1;
                            ram_wr.wr_addr <= base_q + word_cnt_q;
                            ram_wr.wr_data <= word_next;
                            state_q        <= WRITE;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BCW'(1);
                        end
                    end else if (timeout_hit) begin
                        // Any partially assembled word is simply dropped.
                        load_err  <= 1'b1;
                        load_busy <= 1'b0;
                        state_q   <= ERR;
                    end else begin
                        timer_q <= timer_q + 32'd1;
                    end
                end
                WRITE: begin
                    word_cnt_q <= word_cnt_q + ADDR_W'(1);
                    if (!load_start) begin
                        load_busy <= 1'b0;
                        state_q   <= IDLE;
                    end else if (last_word) begin
`ifdef UART_LOADER_CSUM_EN
                        state_q <= CSUM;
`else
                        load_done <= 1'b1;
                        load_busy <= 1'b0;
                        state_q   <= DONE;
`endif
                    end else begin
                        state_q <= RECV;
                    end
                end
`ifdef UART_LOADER_CSUM_EN
                CSUM: begin
                    if (!load_start) begin
                        load_busy <= 1'b0;
                        state_q   <= IDLE;
                    end else if (rx_pulse) begin
                        load_busy <= 1'b0;
                        if (uart_rx_data == load_csum) begin
                            load_done <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            load_err <= 1'b1;
                            state_q  <= ERR;
                        end
                    end else if (timeout_hit) begin
                        load_err  <= 1'b1;
                        load_busy <= 1'b0;
                        state_q   <= ERR;
                    end else begin
                        timer_q <= timer_q + 32'd1;
                    end
                end
`endif
                DONE: begin
                    load_done <= 1'b1;
                    load_busy <= 1'b0;
                    state_q   <= IDLE;
                end
                ERR: begin
                    load_err  <= 1'b1;
                    load_busy <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
